// File: rtl/gcd_pkg.sv
// Shared definitions for the round-robin GCD arbiter and its iterative core.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_NUM_REQ = 4;

endpackage

// File: rtl/gcd_core.sv
// Iterative subtractive-Euclid datapath: loads operands on start, then takes one step per cycle.
module gcd_core
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    // Terminal once either operand is zero or both match; the registers then stay put.
    assign done   = (a_q == '0) || (b_q == '0) || (a_q == b_q);
    assign result = ((a_q == '0) || (b_q == '0)) ? (a_q | b_q) : a_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        a_d = a_q;
        b_d = b_q;
        if (start) begin
            a_d = op_a;
            b_d = op_b;
        end else if (!done) begin
            if (a_q > b_q) begin
                a_d = a_q - b_q;
            end else begin
                b_d = b_q - a_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one GCD core among NUM_REQ requesters, with a registered response channel.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter  int NUM_REQ = DEFAULT_NUM_REQ,
    parameter  int WIDTH   = DEFAULT_WIDTH,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_gcd,
    output logic                     busy
);

    state_e             state_q;
    logic [IDW-1:0]     rr_ptr_q;
    logic [IDW-1:0]     owner_q;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     next_ptr;
    logic               grant_found;
    logic               transfer;
    logic [NUM_REQ-1:0] rot_valid;
    logic [2*NUM_REQ-1:0] valid2;
    int                 pos;
    logic               core_done;
    logic [WIDTH-1:0]   core_result;

    // Rotating a doubled copy puts requester rr_ptr at bit 0, so the first set bit wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        pos         = 0;
        req_ready   = '0;
        valid2      = {req_valid, req_valid};
        rot_valid   = NUM_REQ'(valid2 >> rr_ptr_q);
        if (state_q == IDLE && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!grant_found && rot_valid[k]) begin
                    grant_found = 1'b1;
                    pos         = int'(rr_ptr_q) + k;
                    if (pos >= NUM_REQ) pos = pos - NUM_REQ;
                    grant_id    = IDW'(pos);
                end
            end
            if (grant_found) req_ready = NUM_REQ'(1) << grant_id;
        end
    end

    assign transfer = |(req_valid & req_ready);
    assign next_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign busy     = (state_q != IDLE);

    gcd_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (transfer),
        .op_a   (req_a[grant_id*WIDTH +: WIDTH]),
        .op_b   (req_b[grant_id*WIDTH +: WIDTH]),
        .done   (core_done),
        .result (core_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_gcd   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (transfer) begin
                        owner_q  <= grant_id;
                        rr_ptr_q <= next_ptr;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    if (core_done) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= owner_q;
                        rsp_gcd   <= core_result;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed plus randomized checks of gcd_arbiter against a division-based Euclid and round-robin model.
module tb_gcd_arbiter;

    localparam int NR  = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rsp_ready = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*W-1:0]   req_a = '0;
    logic [NR*W-1:0]   req_b = '0;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_gcd;
    logic              busy;

    int checks    = 0;
    int failures  = 0;
    int model_ptr = 0;
    int exp_id    = 0;
    int exp_gcd   = 0;
    int exp_lat   = 0;

    gcd_arbiter #(
        .NUM_REQ (NR),
        .WIDTH   (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_gcd   (rsp_gcd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Subtractive step count equals the sum of the Euclid quotients.
    function automatic int ref_steps(input int a, input int b);
        int s;
        int t;
        if (a == 0 || b == 0) return 1;
        s = 0;
        while (b != 0) begin
            s = s + a / b;
            t = a % b;
            a = b;
            b = t;
        end
        return s;
    endfunction

    function automatic int ref_pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_valid[i]       = 1'b1;
        req_a[i*W +: W]    = W'(a);
        req_b[i*W +: W]    = W'(b);
    endtask

    // Called at a negedge in IDLE; checks the grant and lets the transfer edge pass.
    task automatic grant_step(input string tag, input logic [NR-1:0] keep);
        int g;
        int a;
        int b;
        logic [NR-1:0] exp_ready;
        #1;
        g = ref_pick(req_valid, model_ptr);
        exp_ready = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            a = int'(req_a[g*W +: W]);
            b = int'(req_b[g*W +: W]);
            exp_id    = g;
            exp_gcd   = ref_gcd(a, b);
            exp_lat   = 1 + ref_steps(a, b);
            model_ptr = (g + 1) % NR;
        end
        check({tag, " grant"}, 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
        req_valid = req_valid & keep;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (rsp_valid === 1'b1) break;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " id"}, 32'(rsp_id), 32'(exp_id));
        check({tag, " gcd"}, 32'(rsp_gcd), 32'(exp_gcd));
    endtask

    task automatic do_txn(input string tag, input logic [NR-1:0] keep);
        grant_step(tag, keep);
        wait_rsp(tag);
        check({tag, " ready in DONE"}, 32'(req_ready), 32'(0));
        @(negedge clk);
    endtask

    initial begin
        set_req(0, 12, 18);
        set_req(1, 21, 14);
        set_req(2, 100, 75);
        set_req(3, 9, 27);
        @(negedge clk);
        #1;
        check("reset ready", 32'(req_ready), 32'(0));
        check("reset rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset rsp_id", 32'(rsp_id), 32'(0));
        check("reset rsp_gcd", 32'(rsp_gcd), 32'(0));
        rst = 1'b0;

        for (int j = 0; j < 5; j++) do_txn("contend", '1);
        req_valid = '0;

        set_req(0, 12, 18);
        do_txn("single 12,18", '0);

        set_req(1, 0, 0);
        do_txn("zero 0,0", '0);
        set_req(2, 0, 35);
        do_txn("zero 0,35", '0);
        set_req(2, 35, 0);
        do_txn("zero 35,0 repeat", '0);
        set_req(3, 255, 1);
        do_txn("worst 255,1", '0);

        set_req(2, 48, 18);
        do_txn("pre-wrap", '0);
        set_req(0, 45, 30);
        set_req(3, 64, 40);
        do_txn("wrap first", 4'b0001);
        do_txn("wrap second", '0);

        rsp_ready = 1'b0;
        set_req(1, 84, 36);
        grant_step("bp", '0);
        wait_rsp("bp");
        set_req(2, 7, 5);
        repeat (10) begin
            @(negedge clk);
            check("bp hold", 32'({rsp_valid, rsp_id, rsp_gcd, req_ready}),
                  32'({1'b1, IDW'(exp_id), W'(exp_gcd), 4'b0000}));
        end
        rsp_ready = 1'b1;
        #1;
        check("bp no grant in DONE", 32'(req_ready), 32'(0));
        @(negedge clk);
        check("bp single rsp", 32'(rsp_valid), 32'(0));
        do_txn("bp next", '0);

        for (int r = 0; r < 16; r++) begin
            logic [NR-1:0] m;
            m = NR'($urandom_range(1, 15));
            for (int i = 0; i < NR; i++) begin
                if (m[i]) set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            end
            do_txn("rand", '0);
        end

        set_req(1, 200, 3);
        grant_step("rst mid-op", '0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst ready", 32'(req_ready), 32'(0));
        @(negedge clk);
        #1;
        check("rst busy", 32'(busy), 32'(0));
        rst = 1'b0;
        model_ptr = 0;
        repeat (5) begin
            @(negedge clk);
            check("rst quiet", 32'({rsp_valid, busy}), 32'(0));
        end
        set_req(1, 30, 12);
        set_req(3, 14, 21);
        do_txn("after rst", '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one GCD engine (2..8).
REQ-002 Parameter WIDTH, default 8, operand and result width in bits.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
REQ-008 req_a  input  NUM_REQ*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH].
REQ-009 req_b  input  NUM_REQ*WIDTH  operand B; same packing as req_a.
REQ-010 rsp_valid  output  1  result valid.
REQ-011 rsp_ready  input  1  result consumer accept.
REQ-012 rsp_id  output  clog2(NUM_REQ)  index of the requester owning the result.
REQ-013 rsp_gcd  output  WIDTH  GCD result.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and DONE.
REQ-016 In IDLE, when any req_valid is high, the block SHALL grant exactly one requester using round-robin order.
  - Search starts at pointer rr_ptr and wraps modulo NUM_REQ.
  - The grant SHALL be driven on req_ready combinationally in the same cycle.
REQ-017 A request SHALL transfer only in a cycle where req_valid[i] and req_ready[i] are both high.
  - On transfer: capture operands, capture id, set rr_ptr to (id+1) mod NUM_REQ, go to CALC.
REQ-018 req_ready SHALL be all-zero in CALC and DONE.
  - A requester SHALL hold req_valid and its operands stable until accepted.
REQ-019 CALC SHALL perform one subtractive Euclid step per cycle on registers a and b:
  - if a==0 or b==0: result = a|b, go to DONE.
  - else if a==b: result = a, go to DONE.
  - else if a>b: a <= a-b.
  - else: b <= b-a.
REQ-020 All arithmetic SHALL be unsigned WIDTH-bit; a subtraction never underflows because the larger operand is always the minuend.
REQ-021 Boundary operand values:
  - gcd(0,x) = x.
  - gcd(x,0) = x.
  - gcd(0,0) = 0, with rsp_valid in cycle T+2.
REQ-022 Latency:
  - If a request transfers in cycle T and CALC takes k step cycles including the terminating cycle, rsp_valid SHALL first be high in cycle T+1+k.
  - Minimum k is 1; worst case for WIDTH=8 is gcd(255,1), k=255.
REQ-023 In DONE, rsp_valid SHALL be high and rsp_id/rsp_gcd SHALL be held stable until rsp_ready is high.
  - On rsp_valid and rsp_ready both high, go to IDLE.
  - A new grant is possible in the following cycle, not the same cycle.
REQ-024 rsp_valid, rsp_id and rsp_gcd SHALL be registered outputs; rsp_id and rsp_gcd SHALL hold their last values outside DONE.
REQ-025 A requester that drops req_valid before being accepted SHALL NOT be served; a sole requester may be granted on consecutive transactions.

Reset
REQ-026 While rst is high at a clock edge, the block SHALL load:
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_gcd=0.
  - internal a=b=0.
REQ-027 Reset asserted in CALC or DONE SHALL abandon the in-flight request with no response.
  - req_ready SHALL be all-zero during any cycle rst is high.

Structure
REQ-028 A shared package gcd_pkg SHALL hold:
  - the state enumeration (IDLE, CALC, DONE);
  - the default WIDTH and NUM_REQ constants.
REQ-029 The iterative datapath SHALL be a sub-module gcd_core, which owns a/b/result and the REQ-019 step.
  - Interface: start, op_a, op_b, done, result.
  - gcd_arbiter owns arbitration, the FSM and the response channel.

Verification
REQ-030 Single request: requester 0 sends a=12, b=18 in cycle T with rsp_ready=1 -> rsp_valid in T+4, rsp_gcd=6, rsp_id=0.
REQ-031 Contention from reset: all four req_valid held high with distinct operands -> grants in order 0,1,2,3,0; each rsp_id matches its grant.
REQ-032 Zero operands:
  - (0,0) -> rsp_gcd=0 at T+2.
  - (0,35) -> rsp_gcd=35 at T+2.
  - (255,1) -> rsp_gcd=1 at T+256.
REQ-033 Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_gcd stay stable, req_ready stays 0, and a single response is delivered when rsp_ready rises.
REQ-034 Reset mid-op: rst pulsed for 1 cycle during CALC of (200,3) -> no rsp_valid, busy=0, rr_ptr=0, and the next request is granted to the lowest valid index.
REQ-035 Pointer wrap: with rr_ptr=3 after serving id 2, requesters 0 and 3 both valid -> 3 is granted first, then 0.
